// File: rtl/cla_pkg.sv
// Shared types and default sizes for the serial carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int SLICE_W = 4;
    localparam int WIDTH_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder: every carry is a flat
// sum-of-products of generate/propagate terms and the slice carry-in.
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;
    logic             w_acc;
    logic             w_prop_run;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, built without a ripple chain.
    always_comb begin
        w_c        = '0;
        w_acc      = 1'b0;
        w_prop_run = 1'b1;
        w_c[0]     = cin;
        for (int i = 0; i < SLICE; i++) begin
            w_acc      = 1'b0;
            w_prop_run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_acc      = w_acc | (w_g[j] & w_prop_run);
                w_prop_run = w_prop_run & w_p[j];
            end
            w_c[i+1] = w_acc | (cin & w_prop_run);
        end
    end

    assign sum  = w_p ^ w_c[SLICE-1:0];
    assign cout = w_c[SLICE];

endmodule

// File: rtl/cla_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one CLA slice per cycle,
// least-significant slice first, with valid/ready on operand and result sides.
module cla_serial_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = WIDTH_W,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, and out_valid holds with stable
    // result/cout/ovf until the edge where out_ready is also high.
    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_result;
    logic              r_cout;
    logic              r_ovf;
    logic              r_out_valid;

    logic [SLICE-1:0]  w_sum;
    logic              w_slice_cout;
    logic              w_last;

    cla_slice #(.SLICE(SLICE)) u_slice (
        .a    (r_a[r_cnt*SLICE +: SLICE]),
        .b    (r_b[r_cnt*SLICE +: SLICE]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_slice_cout)
    );

    assign w_last = (r_cnt == CNT_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= op_a;
                        // Subtraction is a + ~b + 1; the +1 enters as the first carry-in.
                        r_b      <= sub ? ~op_b : op_b;
                        r_carry  <= sub;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_result[r_cnt*SLICE +: SLICE] <= w_sum;
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_cout      <= w_slice_cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_sum[SLICE-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule
